// File: rtl/window_feeder_pkg.sv
// Shared constants and FSM state encoding for the window feeder and processing_block.
package window_feeder_pkg;

  localparam int WF_INPUT_WIDTH     = 8;
  localparam int WF_MAX_LINE_LENGTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PRIMED = 2'd1,
    ST_FLUSH  = 2'd2
  } wf_state_e;

endpackage

// File: rtl/window_feeder.sv
// Slides a 3-tap (left, middle, right) window along each incoming line with edge borders.
// Build option: WINDOW_FEEDER_ZERO_PAD_EN selects zero borders instead of edge replication.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int INPUT_WIDTH     = WF_INPUT_WIDTH,
  parameter int MAX_LINE_LENGTH = WF_MAX_LINE_LENGTH,
  localparam int CW             = $clog2(MAX_LINE_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [INPUT_WIDTH-1:0] left_output,
  output logic [INPUT_WIDTH-1:0] middle_output,
  output logic [INPUT_WIDTH-1:0] right_output,
  output logic                   enable,
  input  logic                   m_ready,
  output logic [CW-1:0]          col_index,
  output logic                   overflow
);

`ifdef WINDOW_FEEDER_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LINE_LENGTH);

  function automatic logic [INPUT_WIDTH-1:0] border(input logic [INPUT_WIDTH-1:0] smp);
    return ZERO_PAD ? '0 : smp;
  endfunction

  wf_state_e              state_q, state_d;
  logic [INPUT_WIDTH-1:0] left_q, left_d, mid_q, mid_d;
  logic [INPUT_WIDTH-1:0] lo_q, lo_d, mo_q, mo_d, ro_q, ro_d;
  logic                   en_q, en_d;
  logic [CW-1:0]          cnt_q, cnt_d, col_q, col_d;
  logic                   ovf_q, ovf_d;
  logic                   slot_free, accept;
  logic [CW-1:0]          cnt_inc;

  assign slot_free = !en_q || m_ready;
  assign s_ready   = reset && slot_free && (state_q != ST_FLUSH);
  assign accept    = s_valid && s_ready;
  // cnt_q counts samples accepted in the current line and saturates at the maximum
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    mid_d   = mid_q;
    lo_d    = lo_q;
    mo_d    = mo_q;
    ro_d    = ro_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    ovf_d   = ovf_q;
    if (slot_free) en_d = 1'b0;
    if (accept && cnt_q == CNT_MAX) ovf_d = 1'b1;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          left_d  = border(s_data);
          mid_d   = s_data;
          cnt_d   = cnt_inc;
          state_d = s_last ? ST_FLUSH : ST_PRIMED;
        end
      end
      ST_PRIMED: begin
        if (accept) begin
          lo_d    = left_q;
          mo_d    = mid_q;
          ro_d    = s_data;
          en_d    = 1'b1;
          col_d   = cnt_q - CW'(1);
          left_d  = mid_q;
          mid_d   = s_data;
          cnt_d   = cnt_inc;
          state_d = s_last ? ST_FLUSH : ST_PRIMED;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          lo_d    = left_q;
          mo_d    = mid_q;
          ro_d    = border(mid_q);
          en_d    = 1'b1;
          col_d   = cnt_q - CW'(1);
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      left_q  <= '0;
      mid_q   <= '0;
      lo_q    <= '0;
      mo_q    <= '0;
      ro_q    <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      mid_q   <= mid_d;
      lo_q    <= lo_d;
      mo_q    <= mo_d;
      ro_q    <= ro_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
    end
  end

  assign left_output   = lo_q;
  assign middle_output = mo_q;
  assign right_output  = ro_q;
  assign enable        = en_q;
  assign col_index     = col_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed, table-driven bench for window_feeder with hand-written multi-cycle corner cases.
module tb_window_feeder;

`ifdef WINDOW_FEEDER_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] left_output, middle_output, right_output;
  logic       enable, m_ready;
  logic [4:0] col_index;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  window_feeder #(.INPUT_WIDTH(8), .MAX_LINE_LENGTH(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .left_output(left_output), .middle_output(middle_output),
    .right_output(right_output), .enable(enable), .m_ready(m_ready),
    .col_index(col_index), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       last;
    logic       mr;
    logic       rdy;
    logic       en;
    logic [7:0] l, m, r;
    logic [4:0] col;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [7:0] bdr(input logic [7:0] x);
    return ZP ? 8'd0 : x;
  endfunction

  function automatic vec_t mkv(input logic vld, input logic [7:0] d, input logic last,
                               input logic mr, input logic rdy, input logic en,
                               input logic [7:0] l, input logic [7:0] m, input logic [7:0] r,
                               input logic [4:0] col);
    vec_t v;
    v.vld = vld; v.d = d; v.last = last; v.mr = mr; v.rdy = rdy;
    v.en = en; v.l = l; v.m = m; v.r = r; v.col = col;
    return v;
  endfunction

  function automatic logic [29:0] win(input logic en, input logic [7:0] l, input logic [7:0] m,
                                      input logic [7:0] r, input logic [4:0] col);
    return {en, l, m, r, col};
  endfunction

  function automatic logic [29:0] cur_win();
    return {enable, left_output, middle_output, right_output, col_index};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] d, input logic last, input logic mr);
    s_valid = vld;
    s_data  = d;
    s_last  = last;
    m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nwin;

  initial begin
    reset = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b1);

    // line 10,20,30,40 then single-sample line 7
    tbl[0] = mkv(1, 8'd10, 0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 5'd0);
    tbl[1] = mkv(1, 8'd20, 0, 1, 1, 1, bdr(8'd10), 8'd10, 8'd20, 5'd0);
    tbl[2] = mkv(1, 8'd30, 0, 1, 1, 1, 8'd10, 8'd20, 8'd30, 5'd1);
    tbl[3] = mkv(1, 8'd40, 1, 1, 1, 1, 8'd20, 8'd30, 8'd40, 5'd2);
    tbl[4] = mkv(1, 8'd99, 0, 1, 0, 1, 8'd30, 8'd40, bdr(8'd40), 5'd3);
    tbl[5] = mkv(1, 8'd7,  1, 1, 1, 0, 8'd30, 8'd40, bdr(8'd40), 5'd3);
    tbl[6] = mkv(0, 8'd0,  0, 1, 0, 1, bdr(8'd7), 8'd7, bdr(8'd7), 5'd0);
    tbl[7] = mkv(0, 8'd0,  0, 1, 1, 0, bdr(8'd7), 8'd7, bdr(8'd7), 5'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_window", {2'b0, cur_win()}, {2'b0, win(0, 8'd0, 8'd0, 8'd0, 5'd0)});
    chk("reset_ovf_rdy", {30'b0, overflow, s_ready}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].vld, tbl[i].d, tbl[i].last, tbl[i].mr);
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].rdy});
      tick();
      chk($sformatf("tbl%0d_window", i), {2'b0, cur_win()},
          {2'b0, win(tbl[i].en, tbl[i].l, tbl[i].m, tbl[i].r, tbl[i].col)});
    end

    // back-pressure: window held, no sample lost
    drive(1, 8'd11, 0, 1); tick();
    drive(1, 8'd12, 0, 1); tick();
    chk("bp_first", {2'b0, cur_win()}, {2'b0, win(1, bdr(8'd11), 8'd11, 8'd12, 5'd0)});
    drive(1, 8'd13, 0, 0);
    #1;
    chk("bp_ready_low", {31'b0, s_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), {2'b0, cur_win()},
          {2'b0, win(1, bdr(8'd11), 8'd11, 8'd12, 5'd0)});
      chk($sformatf("bp_hold%0d_ready", k), {31'b0, s_ready}, 32'd0);
    end
    drive(1, 8'd13, 1, 1);
    #1;
    chk("bp_resume_ready", {31'b0, s_ready}, 32'd1);
    tick();
    chk("bp_resume", {2'b0, cur_win()}, {2'b0, win(1, 8'd11, 8'd12, 8'd13, 5'd1)});
    drive(0, 8'd0, 0, 1); tick();
    chk("bp_flush", {2'b0, cur_win()}, {2'b0, win(1, 8'd12, 8'd13, bdr(8'd13), 5'd2)});
    tick();
    chk("bp_idle", {31'b0, enable}, 32'd0);

    // reset mid-line discards the partial line
    drive(1, 8'd50, 0, 1); tick();
    drive(1, 8'd60, 0, 1); tick();
    reset = 1'b0;
    drive(0, 8'd0, 0, 1);
    #1;
    chk("rst_ready_low", {31'b0, s_ready}, 32'd0);
    tick();
    chk("rst_window", {2'b0, cur_win()}, {2'b0, win(0, 8'd0, 8'd0, 8'd0, 5'd0)});
    reset = 1'b1;
    drive(1, 8'd1, 0, 1); tick();
    chk("rst_no_stale", {31'b0, enable}, 32'd0);
    drive(1, 8'd2, 0, 1); tick();
    chk("rst_w0", {2'b0, cur_win()}, {2'b0, win(1, bdr(8'd1), 8'd1, 8'd2, 5'd0)});
    drive(1, 8'd3, 1, 1); tick();
    chk("rst_w1", {2'b0, cur_win()}, {2'b0, win(1, 8'd1, 8'd2, 8'd3, 5'd1)});
    drive(0, 8'd0, 0, 1); tick();
    chk("rst_w2", {2'b0, cur_win()}, {2'b0, win(1, 8'd2, 8'd3, bdr(8'd3), 5'd2)});
    tick();
    chk("rst_idle", {31'b0, enable}, 32'd0);

    // 17-sample line overflows a 16-sample limit
    nwin = 0;
    for (int k = 1; k <= 17; k++) begin
      drive(1, 8'(k), (k == 17), 1);
      tick();
      if (enable) nwin++;
      if (k == 16) chk("ovf_at16", {31'b0, overflow}, 32'd0);
      if (k == 17) chk("ovf_at17", {31'b0, overflow}, 32'd1);
    end
    drive(0, 8'd0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (enable) nwin++;
    end
    chk("ovf_windows", nwin, 32'd17);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 Parameter INPUT_WIDTH, default 8: sample width in bits.
REQ-002 Parameter MAX_LINE_LENGTH, default 16: maximum samples per line; column counter width is clog2(MAX_LINE_LENGTH+1).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_data  input  INPUT_WIDTH  incoming sample.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  sample is the last of its line; qualified by s_valid.
REQ-008 s_ready  output  1  feeder accepts a sample this cycle.
REQ-009 left_output, middle_output, right_output  output  INPUT_WIDTH each  3-tap window driven into processing_block left/middle/right inputs.
REQ-010 enable  output  1  window valid; drives processing_block enable.
REQ-011 m_ready  input  1  downstream consumes the window this cycle.
REQ-012 col_index  output  clog2(MAX_LINE_LENGTH+1)  column of middle_output within its line.
REQ-013 overflow  output  1  sticky: a line exceeded MAX_LINE_LENGTH.

Function
REQ-014 Sample accepted iff s_valid && s_ready at a rising edge; window consumed iff enable && m_ready.
REQ-015 FSM states EMPTY, PRIMED, FLUSH; reset state EMPTY.
REQ-016 EMPTY: on accept, middle reg <= sample, left reg <= border value; s_last=1 -> FLUSH, else -> PRIMED; no window emitted.
REQ-017 PRIMED: on accept, output regs <= (left reg, middle reg, sample), enable <= 1, col_index <= current column; then left reg <= middle reg, middle reg <= sample; s_last=1 -> FLUSH, else stay.
REQ-018 FLUSH: when output slot free, output regs <= (left reg, middle reg, border value), enable <= 1; -> EMPTY, column counter <= 0.
REQ-019 Border value: replicate edge sample (left border = sample 0, right border = last sample) unless REQ-029 applies.
REQ-020 Output slot free = !enable || m_ready; s_ready = slot free && state != FLUSH (combinational, no dependence on s_valid).
REQ-021 Output regs and enable hold stable while enable && !m_ready; enable drops the cycle after consumption when no new window is loaded.
REQ-022 Latency: window for column x appears the cycle after sample x+1 is accepted; window for last column appears the cycle after FLUSH entry at earliest.
REQ-023 Line of length N yields exactly N windows, col_index 0..N-1 in order.
REQ-024 Accept with column counter == MAX_LINE_LENGTH sets overflow; counter saturates; windows still emitted.
REQ-025 Throughput: one window per cycle sustained with m_ready=1; one bubble cycle per line (FLUSH).

Reset
REQ-026 reset=0 at a rising edge: state EMPTY, enable=0, left/middle/right_output=0, col_index=0, overflow=0, internal regs 0; applies mid-line, discarding any partial line.
REQ-027 s_ready=0 while reset=0.
REQ-028 overflow clears only on reset.

Configuration
REQ-029 WINDOW_FEEDER_ZERO_PAD_EN defined: border value is 0 on both edges; undefined: edge replication per REQ-019.

Structure
REQ-030 Shared package holds the FSM state enum and the default INPUT_WIDTH/MAX_LINE_LENGTH constants used by processing_block and window_feeder.
REQ-031 Single module; no sub-modules.

Verification
REQ-032 Line 10,20,30,40 (last on 40), m_ready=1 -> windows (10,10,20),(10,20,30),(20,30,40),(30,40,40), col_index 0..3, one idle cycle before next line.
REQ-033 Same line with WINDOW_FEEDER_ZERO_PAD_EN -> first window (0,10,20), last (30,40,0).
REQ-034 Single-sample line 7 with s_last -> exactly one window (7,7,7), col_index 0.
REQ-035 m_ready=0 for 3 cycles mid-line -> window and enable held stable, s_ready=0, no sample lost; resumes in order on m_ready=1.
REQ-036 reset=0 asserted after 2 samples of a line, then new line 1,2,3 -> no stale window; outputs (1,1,2),(1,2,3),(2,3,3).
REQ-037 17-sample line with MAX_LINE_LENGTH=16 -> overflow=1 after 17th accept, remains 1 until reset.
